// File: rtl/array_method_responder.sv
// Method-call responder that owns a DEPTH-word array behind a direct read/write port
// and implements a "check" method: optional fill with i+seed, then verify every entry.
module array_method_responder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] arr_idx,
    input  logic        arr_we,
    input  logic [31:0] arr_in,
    output logic [31:0] arr_out,
    input  logic [31:0] check_seed,
    input  logic        check_fill,
    input  logic        check_req,
    output logic        check_busy,
    output logic        check_return,
    output logic [31:0] check_errors
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        VERIFY,
        FLUSH
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0]   seed;
    logic [31:0]   err_cnt;
    logic [31:0]   err_next;
    logic [31:0]   rd_data;
    logic [31:0]   rd_exp;
    logic          rd_valid;

    logic          ext_in_range;
    logic [AW-1:0] ext_addr;
    logic          last_idx;
    logic          cmp_en;
    logic          mismatch;

    assign ext_in_range = (arr_idx < 32'(DEPTH));
    assign ext_addr     = arr_idx[AW-1:0];
    assign last_idx     = (idx == AW'(DEPTH - 1));
    assign mismatch     = (rd_data != rd_exp);

    // NOTE: every variable driven here gets a default first, so no path leaves a latch.
    always_comb begin
        state_next = state;
        cmp_en     = 1'b0;
        case (state)
            IDLE: begin
                if (check_req) begin
                    state_next = check_fill ? FILL : VERIFY;
                end
            end
            FILL: begin
                if (last_idx) begin
                    state_next = VERIFY;
                end
            end
            VERIFY: begin
                // The first VERIFY cycle only issues a read; nothing to compare yet.
                cmp_en = rd_valid;
                if (last_idx) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                cmp_en     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturating increment; unreachable with DEPTH <= 1024 but kept for safety.
    assign err_next = (cmp_en && mismatch && (err_cnt != '1)) ? err_cnt + 32'd1 : err_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            check_busy   <= 1'b0;
            check_return <= 1'b0;
            check_errors <= '0;
            arr_out      <= '0;
            idx          <= '0;
            seed         <= '0;
            err_cnt      <= '0;
            rd_data      <= '0;
            rd_exp       <= '0;
            rd_valid     <= 1'b0;
        end else begin
            state   <= state_next;
            err_cnt <= err_next;
            arr_out <= ext_in_range ? mem[ext_addr] : '0;
            case (state)
                IDLE: begin
                    if (check_req) begin
                        seed       <= check_seed;
                        err_cnt    <= '0;
                        idx        <= '0;
                        rd_valid   <= 1'b0;
                        check_busy <= 1'b1;
                    end
                end
                FILL: begin
                    // DEPTH is a power of two, so the index wraps to 0 after the last entry.
                    idx <= idx + AW'(1);
                end
                VERIFY: begin
                    rd_data  <= mem[idx];
                    rd_exp   <= 32'(idx) + seed;
                    rd_valid <= 1'b1;
                    idx      <= idx + AW'(1);
                end
                FLUSH: begin
                    check_errors <= err_next;
                    check_return <= (err_next == '0);
                    check_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the array is deliberately left unreset so contents survive reset and it maps onto RAM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == FILL) begin
                mem[idx] <= 32'(idx) + seed;
            end else if (state == IDLE && arr_we && ext_in_range) begin
                mem[ext_addr] <= arr_in;
            end
        end
    end

endmodule

// File: doc/array_method_responder.md
# array_method_responder

Synthesizable responder for the method-call handshake (`*_req` / `*_busy` / `*_return`) used by the generated top-level tests. It owns a DEPTH-word array that is reachable through a direct array port (`arr_idx` / `arr_we` / `arr_in` / `arr_out`). It also implements one method, `check`, which can optionally fill the array and then verifies every entry against `i + seed`. It is the callee that a simulation driver or a generated caller module invokes; it reports pass/fail and a mismatch count.

## Interface
- `DEPTH`, 16: number of 32-bit array entries; power of two, 2..1024.
- `AW`, 4: log2(DEPTH).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `arr_idx`  in  32  array index for the external port; only `[AW-1:0]` are used when in range.
- `arr_we`  in  1  external write strobe.
- `arr_in`  in  32  external write data.
- `arr_out`  out  32  registered read data for `arr_idx`.
- `check_seed`  in  32  method argument, sampled at call start.
- `check_fill`  in  1  method argument, sampled at call start; 1 = fill then verify, 0 = verify only.
- `check_req`  in  1  level-sensitive call request.
- `check_busy`  out  1  high while the method executes.
- `check_return`  out  1  1 = last call found zero mismatches.
- `check_errors`  out  32  mismatch count of the last completed call.

## Operation
- **Reset** (sync, at posedge with `reset`=1):
  - state=IDLE.
  - `check_busy`=0, `check_return`=0, `check_errors`=0, `arr_out`=0.
  - Array contents are not reset.
- **External port**:
  - Every cycle, `arr_out` <= (`arr_idx` < DEPTH) ? mem[`arr_idx`] : 0. The read is registered and reads old data on a same-address write.
  - Writes take effect only when `arr_we`=1, state=IDLE and `arr_idx` < DEPTH.
  - Out-of-range writes and any write while busy are dropped silently.
- **FSM states**: IDLE, FILL, VERIFY, FLUSH.
  - **IDLE**: when `check_req`=1, latch seed and fill, clear the internal error counter, and set i=0. Go to FILL if fill=1, else VERIFY. Set `check_busy`=1.
  - **FILL**: write mem[i] = i + seed (mod 2^32) and increment i. After i=DEPTH-1, set i=0 and go to VERIFY.
  - **VERIFY**: issue a read of mem[i] and increment i. From the second VERIFY cycle onward, compare the previous read data with (i_prev + seed); on inequality, increment the error counter. After issuing i=DEPTH-1, go to FLUSH.
  - **FLUSH**: compare the last read. Then, on the same edge:
    - `check_errors` <= final count (including this compare).
    - `check_return` <= (final count == 0).
    - `check_busy` <= 0.
    - state <= IDLE.
- **Outputs during a call**: `check_return` and `check_errors` hold the previous call's values until FLUSH updates them.
- **Arithmetic**: the error counter is 32 bits and saturates at 0xFFFFFFFF. Because errors are at most DEPTH, saturation cannot occur in practice, but it is required. The seed addition wraps modulo 2^32.
- **Request held high**: the block returns to IDLE with busy=0 for exactly one cycle, then restarts on the next edge.
- **Request changes while busy**: `check_req` is ignored, and changes to `check_seed` / `check_fill` have no effect.
- **Reset mid-call**: the call is abandoned and outputs return to their reset values. Entries already written in FILL stay written.

## Timing
- `check_busy` rises on the edge after `check_req` is first seen high in IDLE.
- busy-high duration:
  - 2·DEPTH+1 cycles with fill=1.
  - DEPTH+1 cycles with fill=0.
- `check_return` / `check_errors` are valid on the same edge at which `check_busy` falls.
- Read data comparison lags the read address by 1 cycle; the FLUSH state absorbs this lag.
- `arr_out` latency is 1 cycle from `arr_idx`.
- The external port is unavailable for writes while busy, but reads stay live. They may return values that FILL is changing.

## Test plan
- **Reset**: hold `reset` high for cycles 3–8 -> all outputs 0 on the first edge with reset high. `check_busy` stays 0 with no request.
- **Fill-and-verify** (DEPTH=16, seed=0x100, fill=1): pulse `check_req` -> busy high for exactly 33 cycles, then `check_return`=1, `check_errors`=0. A read of `arr_idx`=5 afterwards gives 0x105 one cycle later.
- **Verify-only with corruption**:
  - Setup: after the fill above, write `arr_idx`=3 -> 0 and `arr_idx`=15 -> 0xDEAD in IDLE.
  - Stimulus: call with fill=0, seed=0x100.
  - Required response: busy for 17 cycles, `check_return`=0, `check_errors`=2.
- **Dropped writes**:
  - During busy, assert `arr_we` with `arr_idx`=7 and data 0 -> the call still returns 1, and mem[7] afterwards is 0x107.
  - A write to `arr_idx`=16 in IDLE -> no entry changes; a read of `arr_idx`=16 gives 0.
- **Level request**: hold `check_req` high continuously -> busy pattern is 33 high, 1 low, 33 high, repeating. `check_return` stays 1 throughout.
- **Reset mid-call**: assert `reset` in cycle 10 of a fill call -> busy=0, `check_return`=0 and `check_errors`=0 next edge. A fresh verify-only call with seed=0x100 reports `check_errors`=16-k, where k is the number of entries refilled before reset (k=9 in this case).
